// File: rtl/m_bp_resolve_queue.sv
// In-order queue of predicted conditional branches between fetch and execute.
// Resolves oldest-first, drives the gshare update port, and flags mispredicts.
module m_bp_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int IDXW  = 5,
  parameter int AW    = 32
) (
  input  logic            w_clk,
  input  logic            w_rst,
  input  logic            w_enq,
  input  logic [IDXW-1:0] w_enq_idx,
  input  logic [AW-1:0]   w_enq_pc,
  input  logic            w_enq_pred,
  input  logic            w_res,
  input  logic            w_res_tkn,
  input  logic [AW-1:0]   w_res_tgt,
  input  logic            w_flush,
  output logic            w_full,
  output logic            w_empty,
  output logic            r_upd_we,
  output logic [IDXW-1:0] r_upd_adr,
  output logic            r_upd_tkn,
  output logic            r_mispred,
  output logic [AW-1:0]   r_redirect_pc,
  output logic [31:0]     r_nbr,
  output logic [31:0]     r_nmiss,
  output logic            r_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   head, tail, head_next;
  logic [CW-1:0]   count;

  logic [IDXW-1:0] mem_idx  [DEPTH];
  logic [AW-1:0]   mem_pc   [DEPTH];
  logic            mem_pred [DEPTH];

  logic res_acc, enq_acc, mis_now, squash;

  assign w_full  = (count == CW'(DEPTH));
  assign w_empty = (count == '0);

  // Full is judged on the pre-resolve count: a slot freed this cycle is not reused.
  always_comb begin
    res_acc   = w_res & ~w_empty;
    mis_now   = res_acc & (mem_pred[head] != w_res_tkn);
    enq_acc   = w_enq & ~w_full & ~w_flush & ~mis_now;
    squash    = mis_now | w_flush;
    head_next = head + PW'(res_acc);
  end

  always_ff @(posedge w_clk) begin
    if (enq_acc) begin
      mem_idx[tail]  <= w_enq_idx;
      mem_pc[tail]   <= w_enq_pc;
      mem_pred[tail] <= w_enq_pred;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= head_next;
      if (squash) begin
        tail  <= head_next;
        count <= '0;
      end else begin
        tail  <= tail + PW'(enq_acc);
        count <= count + CW'(enq_acc) - CW'(res_acc);
      end
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_upd_we      <= 1'b0;
      r_upd_adr     <= '0;
      r_upd_tkn     <= 1'b0;
      r_mispred     <= 1'b0;
      r_redirect_pc <= '0;
      r_nbr         <= '0;
      r_nmiss       <= '0;
      r_err         <= 1'b0;
    end else begin
      r_upd_we  <= res_acc;
      r_mispred <= mis_now;
      if (res_acc) begin
        r_upd_adr     <= mem_idx[head];
        r_upd_tkn     <= w_res_tkn;
        r_redirect_pc <= w_res_tkn ? w_res_tgt : mem_pc[head] + AW'(4);
        r_nbr         <= r_nbr + 32'd1;
      end
      if (mis_now)
        r_nmiss <= r_nmiss + 32'd1;
      if (w_res & w_empty)
        r_err <= 1'b1;
    end
  end

endmodule

// File: doc/m_bp_resolve_queue.md
Name: m_bp_resolve_queue

Overview:
- In-order queue of in-flight conditional branches, sitting between fetch and execute.
- Fetch pushes each predicted branch's predictor index, PC and predicted direction. Execute resolves branches oldest-first.
- The block drives the gshare predictor's write port (write-enable, write-address, taken) and raises a one-cycle mispredict/redirect to fetch.
- It also keeps branch and mispredict statistics counters.

Parameters:
- DEPTH, 4, number of in-flight branch entries (power of two, ≥2).
- IDXW, 5, predictor index width (matches the 32-entry counter table).
- AW, 32, PC width.

Ports:
- w_clk  input  1  clock; all state changes on posedge.
- w_rst  input  1  reset; asynchronous, active-high.
- w_enq  input  1  fetch pushes a predicted branch this cycle.
- w_enq_idx  input  IDXW  predictor read index used at fetch (PC[IDXW+1:2]).
- w_enq_pc  input  AW  branch PC.
- w_enq_pred  input  1  predicted direction (1 = taken).
- w_res  input  1  execute resolves the oldest branch this cycle.
- w_res_tkn  input  1  actual direction.
- w_res_tgt  input  AW  actual taken target.
- w_flush  input  1  external squash (exception/interrupt).
- w_full  output  1  queue holds DEPTH entries; combinational from count.
- w_empty  output  1  queue holds 0 entries; combinational from count.
- r_upd_we  output  1  predictor write-enable pulse.
- r_upd_adr  output  IDXW  predictor write index.
- r_upd_tkn  output  1  actual direction for counter update.
- r_mispred  output  1  mispredict pulse to fetch.
- r_redirect_pc  output  AW  correct next PC, valid while r_mispred = 1.
- r_nbr  output  32  resolved-branch counter.
- r_nmiss  output  32  mispredict counter.
- r_err  output  1  sticky: resolve arrived while queue empty.

Behaviour:
- Reset (async, w_rst = 1): head = tail = count = 0. Every r_* output is 0.
- Storage: circular buffer, DEPTH entries of {idx, pc, pred}. Head and tail pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Enqueue accepted iff w_enq & !w_full & !w_flush & !mispredict-this-cycle. On accept, write at tail and increment tail. An enqueue while full is silently dropped.
- Resolve accepted iff w_res & !w_empty. On accept:
  - Read the head entry and increment head.
  - Mispredict-this-cycle = (pred != w_res_tkn).
  - Next cycle: r_upd_we = 1, r_upd_adr = head.idx, r_upd_tkn = w_res_tkn.
  - Next cycle: r_mispred = mispredict-this-cycle.
  - r_redirect_pc = w_res_tkn ? w_res_tgt : head.pc + 4, computed modulo 2^AW.
  - r_nbr increments; r_nmiss increments on mispredict. Both wrap at 2^32.
- Resolve while empty: ignored; r_err is set and held until reset.
- Update latency: exactly 1 cycle from resolve edge to r_upd_we/r_mispred.
  - r_upd_we and r_mispred are single-cycle pulses, 0 in any cycle without an accepted resolve.
  - r_upd_adr, r_upd_tkn and r_redirect_pc hold their last value otherwise.
- Mispredict squash: in the resolving cycle, all younger entries are discarded (head, tail and count go to the post-resolve head, count 0). A same-cycle enqueue is dropped (wrong path).
- w_flush: clears the queue (count 0, tail = head). It has priority over enqueue. A same-cycle resolve is still processed normally (update, counters, mispredict pulse).
- Simultaneous accepted enqueue and resolve with no mispredict: count unchanged. Legal when full (the entry freed by the resolve is not reused the same cycle, so full-enqueue is still dropped).
- Count arithmetic: count_next = count + enq_acc − res_acc, overridden to 0 by squash or flush.
- Reset asserted mid-operation: all state is cleared immediately (asynchronously). Any pending update pulse is lost.

Test Plan:
- Reset then idle 5 cycles -> w_empty = 1, w_full = 0, all r_* = 0.
- Enq idx = 3 pc = 0x100 pred = 1, then resolve tkn = 1 tgt = 0x200 -> next cycle: r_upd_we = 1, adr = 3, tkn = 1, r_mispred = 0, r_nbr = 1, r_nmiss = 0.
- Enq idx = 7 pc = 0x40 pred = 1, resolve tkn = 0 -> r_mispred = 1, r_redirect_pc = 0x44, r_nmiss = 1.
- Enq 4 branches (w_full = 1), 5th enq dropped. Resolve the first as a mispredict in the same cycle as an enqueue -> queue empty, enq dropped, r_mispred = 1.
- Fill 3 entries, assert w_flush with a resolve of the oldest (correct) -> update pulse for the oldest entry, w_empty = 1 next cycle.
- Resolve while empty -> no r_upd_we, r_err = 1 and stays 1 until w_rst; assert w_rst asynchronously mid-cycle -> outputs clear before the next edge.
